// File: rtl/divisor_secuencial_if.sv
// Start/done handshake bundle for the sequential divider.
// The master drives operands and start; the slave returns the result.
interface divisor_secuencial_if #(
    parameter int BIT = 4
);
    logic           start;
    logic [BIT-1:0] num1;
    logic [BIT-1:0] num2;
    logic [BIT-1:0] Cociente;
    logic [BIT-1:0] Residuo;
    logic           busy;
    logic           done;
    logic           DIVZERO;

    modport master (
        output start, num1, num2,
        input  Cociente, Residuo, busy, done, DIVZERO
    );

    modport slave (
        input  start, num1, num2,
        output Cociente, Residuo, busy, done, DIVZERO
    );
endinterface

// File: rtl/divisor_secuencial.sv
// Iterative restoring unsigned divider, one quotient bit per cycle.
// Companion of the combinational multiplier in the ALU datapath.
module divisor_secuencial #(
    parameter int BIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    divisor_secuencial_if.slave  bus
);
    localparam int CW = $clog2(BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(BIT - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [BIT-1:0] r_q;
    logic [BIT-1:0] r_d;
    logic [BIT:0]   r_r;
    logic [CW-1:0]  r_cnt;
    logic           r_dz;
    logic [BIT-1:0] r_coc;
    logic [BIT-1:0] r_res;
    logic           r_done;
    logic           r_divzero;
    logic [BIT:0]   w_shift;
    logic [BIT:0]   w_t;

    // Trial subtraction of the shifted partial remainder.
    assign w_shift = {r_r[BIT-1:0], r_q[BIT-1]};
    assign w_t     = w_shift - {1'b0, r_d};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = (bus.num2 != '0) ? CALC : FIN;
                end
            end
            CALC: begin
                if (r_cnt == LAST) begin
                    w_next = FIN;
                end
            end
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= '0;
            r_d       <= '0;
            r_r       <= '0;
            r_cnt     <= '0;
            r_dz      <= 1'b0;
            r_coc     <= '0;
            r_res     <= '0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_q   <= bus.num1;
                        r_d   <= bus.num2;
                        r_r   <= '0;
                        r_cnt <= '0;
                        r_dz  <= (bus.num2 == '0);
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!w_t[BIT]) begin
                        r_r <= w_t;
                        r_q <= {r_q[BIT-2:0], 1'b1};
                    end else begin
                        r_r <= w_shift;
                        r_q <= {r_q[BIT-2:0], 1'b0};
                    end
                end
                FIN: begin
                    r_done <= 1'b1;
                    // Q never shifted on the zero-divisor path, so it still holds num1.
                    if (r_dz) begin
                        r_coc     <= '1;
                        r_res     <= r_q;
                        r_divzero <= 1'b1;
                    end else begin
                        r_coc     <= r_q;
                        r_res     <= r_r[BIT-1:0];
                        r_divzero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Cociente = r_coc;
    assign bus.Residuo  = r_res;
    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = r_done;
    assign bus.DIVZERO  = r_divzero;
endmodule

// File: tb/tb_divisor_secuencial.sv
// Self-checking bench for divisor_secuencial: vector table, corner
// sequences and an exhaustive sweep, all checked through a scoreboard.
module tb_divisor_secuencial;
    localparam int BIT = 4;

    typedef struct {
        logic [BIT-1:0] n1;
        logic [BIT-1:0] n2;
        logic [BIT-1:0] q;
        logic [BIT-1:0] r;
        logic           dz;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   dones = 0;
    int   ops = 0;
    vec_t sb[$];

    divisor_secuencial_if #(.BIT(BIT)) bif ();

    divisor_secuencial #(.BIT(BIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t model(input int a, input int b);
        vec_t v;
        v.n1 = BIT'(a);
        v.n2 = BIT'(b);
        if (b == 0) begin
            v.q  = '1;
            v.r  = BIT'(a);
            v.dz = 1'b1;
        end else begin
            v.q  = BIT'(a / b);
            v.r  = BIT'(a % b);
            v.dz = 1'b0;
        end
        return v;
    endfunction

    // Shift-and-add product, standing in for the array multiplier.
    function automatic int mul(input int a, input int b);
        int p = 0;
        for (int i = 0; i < BIT; i++) begin
            if (b[i]) p = p + (a << i);
        end
        return p;
    endfunction

    always @(negedge clk) begin
        if (bif.done) begin
            dones++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                vec_t e;
                e = sb.pop_front();
                check("cociente", int'(bif.Cociente), int'(e.q));
                check("residuo", int'(bif.Residuo), int'(e.r));
                check("divzero", int'(bif.DIVZERO), int'(e.dz));
                if (!e.dz) begin
                    check("invariant_sum",
                          mul(int'(bif.Cociente), int'(e.n2)) + int'(bif.Residuo),
                          int'(e.n1));
                    check("invariant_rlt",
                          int'(int'(bif.Residuo) < int'(e.n2)), 1);
                end
            end
        end
    end

    // Called at a negedge while the DUT is idle; returns at the negedge
    // just after the accepting edge.
    task automatic start_op(input vec_t v);
        bif.start = 1'b1;
        bif.num1  = v.n1;
        bif.num2  = v.n2;
        sb.push_back(v);
        ops++;
        @(negedge clk);
        bif.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!bif.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 40) check("done_timeout", cyc, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int   cyc;
        int   d0;

        tbl[0] = '{4'd13, 4'd4,  4'd3,  4'd1, 1'b0};
        tbl[1] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0};
        tbl[2] = '{4'd3,  4'd7,  4'd0,  4'd3, 1'b0};
        tbl[3] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0};
        tbl[4] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0};
        tbl[5] = '{4'd9,  4'd0,  4'd15, 4'd9, 1'b1};
        tbl[6] = '{4'd8,  4'd2,  4'd4,  4'd0, 1'b0};

        bif.start = 1'b0;
        bif.num1  = '0;
        bif.num2  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", int'(bif.busy), 0);
        check("rst_done", int'(bif.done), 0);
        check("rst_coc", int'(bif.Cociente), 0);
        check("rst_res", int'(bif.Residuo), 0);
        check("rst_dz", int'(bif.DIVZERO), 0);

        for (int i = 0; i < 7; i++) begin
            start_op(tbl[i]);
            check("busy_after_start", int'(bif.busy), 1);
            wait_done(cyc);
            check("latency", cyc, tbl[i].dz ? 1 : BIT + 1);
            @(negedge clk);
            check("done_one_cycle", int'(bif.done), 0);
        end

        // Starts during CALC and FIN must be ignored.
        d0 = dones;
        start_op(model(14, 3));
        bif.start = 1'b1;
        bif.num1  = 4'd7;
        bif.num2  = 4'd7;
        @(negedge clk);
        bif.start = 1'b0;
        repeat (3) @(negedge clk);
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        check("ignored_done", int'(bif.done), 1);
        repeat (8) @(negedge clk);
        check("ignored_pulses", dones - d0, 1);
        check("ignored_busy", int'(bif.busy), 0);

        // Reset two cycles into an operation aborts it.
        d0 = dones;
        start_op(model(12, 5));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        ops--;
        check("abort_busy", int'(bif.busy), 0);
        check("abort_done", int'(bif.done), 0);
        check("abort_coc", int'(bif.Cociente), 0);
        check("abort_res", int'(bif.Residuo), 0);
        check("abort_dz", int'(bif.DIVZERO), 0);
        repeat (8) @(negedge clk);
        check("abort_no_done", dones - d0, 0);
        start_op(model(12, 5));
        wait_done(cyc);
        check("after_abort_latency", cyc, BIT + 1);
        @(negedge clk);

        // Exhaustive sweep, each start issued in the done cycle.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                start_op(model(a, b));
                wait_done(cyc);
            end
        end
        @(negedge clk);

        check("all_done_count", dones, ops);
        check("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/divisor_secuencial.md
Name: divisor_secuencial

Overview:
- Iterative restoring unsigned divider: the inverse operation of the team's combinational array multiplier `multiplicador`.
- Takes dividend num1 and divisor num2, both BIT wide, and produces quotient and remainder after BIT iteration cycles.
- Uses a start/done handshake.
- Sits beside `multiplicador` in the ALU datapath; the bench uses that multiplier to cross-check results.

Parameters:
- BIT, 4, operand width in bits; also the number of iteration cycles (legal range 2..16).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request pulse; sampled only in state IDLE.
- num1  input  BIT  dividend (unsigned); captured on accepted start.
- num2  input  BIT  divisor (unsigned); captured on accepted start.
- Cociente  output  BIT  quotient.
- Residuo  output  BIT  remainder.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: results valid.
- DIVZERO  output  1  divisor was zero for the last completed operation.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high. Ports are clk and rst.
  - rst=1 at a clock edge forces: state IDLE; Cociente=0, Residuo=0, busy=0, done=0, DIVZERO=0; iteration counter=0; internal registers=0.
  - rst takes priority over start and aborts any operation in flight. No done is issued for an aborted operation.
- FSM states: IDLE, CALC, FIN.
  - busy = (state != IDLE).
  - done = (state == FIN), registered.
- IDLE:
  - start=1 at edge t: latch num1 into the quotient shift register Q and num2 into D.
  - Clear the partial remainder R (BIT+1 bits) and the counter.
  - If num2 != 0, go to CALC; if num2 == 0, go to FIN.
  - start=0: stay in IDLE; outputs hold their last values.
- CALC: one restoring step per cycle.
  - T = {R[BIT-1:0], Q[BIT-1]} - {1'b0, D}, computed at BIT+1 width.
  - If T is non-negative (MSB=0): R<=T and Q<={Q[BIT-2:0],1}.
  - Otherwise: R<={R[BIT-1:0],Q[BIT-1]} and Q<={Q[BIT-2:0],0}.
  - Counter increments each step. After the BIT-th step (counter==BIT-1), go to FIN.
- FIN (exactly one cycle):
  - Cociente<=Q, Residuo<=R[BIT-1:0], DIVZERO<=0, done=1.
  - Then go to IDLE.
- Divide-by-zero path:
  - On entering FIN from IDLE: Cociente=all ones (2**BIT-1), Residuo=num1 as latched, DIVZERO=1.
- Latency:
  - Normal: start sampled at edge t gives done=1 in the cycle after edge t+BIT+1.
  - Divide by zero: done at edge t+1.
  - Throughput: one result per BIT+2 cycles.
- start while busy=1, including the FIN cycle: ignored, no queuing. The latched operands are unaffected by input changes after acceptance.
- Outputs update only on FIN (or on rst); they are stable between done pulses.
- Invariant for every non-zero divisor: Cociente*num2 + Residuo == num1 and Residuo < num2.
- No overflow is possible: the quotient always fits in BIT bits.

Test Plan:
- BIT=4, start with num1=13, num2=4:
  - busy rises at the next edge;
  - done pulses once, BIT+1 edges after the accepting edge;
  - Cociente=3, Residuo=1, DIVZERO=0.
- Boundaries with BIT=4:
  - 15/1 -> Cociente=15, Residuo=0.
  - 3/7 -> Cociente=0, Residuo=3.
  - 0/5 -> Cociente=0, Residuo=0.
  - 15/15 -> Cociente=1, Residuo=0.
- num1=9, num2=0 -> done one cycle after acceptance; Cociente=15, Residuo=9, DIVZERO=1. A following 8/2 operation -> Cociente=4, Residuo=0, DIVZERO cleared to 0.
- 14/3 accepted; start pulsed with 7/7 during CALC and again during FIN:
  - both pulses ignored;
  - result is Cociente=4, Residuo=2;
  - exactly one done pulse.
- rst asserted two cycles into a 12/5 operation:
  - next edge: busy=0, done=0, all outputs 0, no done pulse;
  - a new 12/5 started afterwards completes with Cociente=2, Residuo=2.
- Exhaustive sweep, BIT=4, all 256 (num1,num2) pairs with back-to-back starts issued in IDLE:
  - for num2!=0, `multiplicador`(Cociente,num2)+Residuo equals num1 and Residuo<num2;
  - for num2=0, the divide-by-zero values above.
